radix4_srt_div: RTL and testbench
=================================

Name: radix4_srt_div

Overview:
- Sequential 32-bit radix-4 SRT integer divider for RV32M DIV/DIVU/REM/REMU.
- Sits directly upstream of the quotient-digit selection table `radix4_table`.
- Each cycle it normalizes and forms the partial remainder, drives the table's index/expand inputs, and consumes the returned digit.
- Also does on-the-fly quotient conversion, final correction and sign fix-up; single-issue, valid/ready on both sides.

Parameters:
- XLEN, 32, operand width; only 32 supported.
- ITERS, 17, radix-4 iterations (34 shifted-in bits / 2); derived, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  abort in-flight op; return to IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_a  in  32  dividend.
- in_b  in  32  divisor.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts.
- out_result  out  32  quotient or remainder per op.

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, out_result=0, in_ready=1 after reset; all datapath registers 0.
- FSM:
  - IDLE→NORM on in_valid&in_ready; latch op and operand magnitudes (|a|,|b| for signed ops), sign_q = signed & (a[31]^b[31]), sign_r = signed & a[31].
  - NORM:
    - if b==0: result = all-ones (DIV/DIVU) or a (REM/REMU), unsigned, →DONE.
    - else: lzd = clz(|b|); D = |b|<<lzd (D[31]=1); X' = |a|<<lzd (64-bit); W = X'[63:34] zero-extended to 36-bit signed; Q=QM=0; cnt=0; →ITER.
  - ITER, one digit per cycle:
    - P = 4W + next 2 bits of X'[33:0], MSB first, 38-bit signed.
    - Table inputs: dividend_index=P[34:28], divisor_index=D[31:28], dividend_expand=P[27:25], dividend_expand_ex=P[24:22], divisor_expand=D[27:26], divisor_expand_ex=D[25:24].
    - Decode q_table: bit2 sign, bits[1:0] magnitude 00/01/10.
    - W ← P − q·D, truncated to 36 bits.
    - →FIX after cnt==ITERS−1.
  - On-the-fly conversion, 34-bit Q/QM:
    - q>0: Q={Q,q}, QM={Q,q−1}.
    - q=0: Q={Q,0}, QM={QM,3}.
    - q<0: Q={QM,4+q}, QM={QM,3+q}.
  - FIX:
    - if W<0: quo=QM, rem=W+D; else quo=Q, rem=W.
    - rem >>= lzd.
    - Negate quo if sign_q, rem if sign_r.
    - out_result = quo[31:0] or rem[31:0]; →DONE.
  - DONE: out_valid=1; on out_ready →IDLE, out_valid=0 next cycle.
- Latency, counted from the acceptance edge:
  - normal op: out_valid first high 20 cycles later.
  - divide-by-zero: 2 cycles later.
  - Fixed, independent of data.
- Overflow (0x80000000 / −1): no special path; natural result 0x80000000 quotient, 0 remainder.
- Invariant |W| ≤ (2/3)·D each iteration; bench asserts it.
- flush:
  - in any state: next cycle IDLE, out_valid=0, result discarded.
  - flush with DONE & out_ready in the same cycle: the transfer completes.
  - flush in IDLE with in_valid: request not accepted.
- in_ready=0 outside IDLE; in_* ignored there.
- out_result stable while out_valid & !out_ready.

Optional Feature:
- Macro DIV_EARLY_TERM_EN.
- Defined: in NORM, if b!=0 and |a| < |b| (unsigned magnitudes), bypass ITER: quo=0, rem=|a|, apply sign fix, →DONE. Latency 2.
- Undefined: every nonzero-divisor op takes the full 20-cycle path; results are identical either way.

Decomposition:
- Shared package `div_pkg`:
  - op encodings (DIV_OP_DIV/DIVU/REM/REMU).
  - quotient digit encoding (QD_SIGN bit, QD_MAG_0/1/2).
  - ITERS and XLEN constants.
  - FSM state enum (IDLE, NORM, ITER, FIX, DONE).
- Sub-module: instantiate the existing `radix4_table` as the digit-selection sub-block.
- clz is a local function; no further sub-modules.

Test Plan:
- DIVU 100/7 → out_result 14, out_valid exactly 20 cycles after accept; REMU 100%7 → 2.
- DIV −100 (0xFFFFFF9C) / 7 → 0xFFFFFFF2; REM → 0xFFFFFFFE; DIV 100 / −7 → 0xFFFFFFF2.
- DIV 0x1234/0 → 0xFFFFFFFF; REM 0x1234/0 → 0x1234; out_valid 2 cycles after accept.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- DIVU 0xFFFFFFFF/0xFFFFFFFE with out_ready low 5 cycles → 1, held stable; in_ready=0 throughout; accepted on 6th.
- flush asserted in 8th ITER cycle → IDLE next cycle, no out_valid; following DIVU 9/3 → 3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings for the radix-4 SRT divider: op codes, quotient-digit format,
// iteration count and FSM states.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 17;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Quotient digit: bit QD_SIGN is the sign, bits [1:0] the magnitude.
    localparam int         QD_SIGN  = 2;
    localparam logic [1:0] QD_MAG_0 = 2'b00;
    localparam logic [1:0] QD_MAG_1 = 2'b01;
    localparam logic [1:0] QD_MAG_2 = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ITER,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/radix4_table.sv
// Radix-4 quotient-digit selection (digit set -2..2) from truncated partial
// remainder and normalized divisor estimates.
module radix4_table
    import div_pkg::*;
(
    input  logic [6:0] dividend_index,
    input  logic [3:0] divisor_index,
    input  logic [2:0] dividend_expand,
    input  logic [2:0] dividend_expand_ex,
    input  logic [1:0] divisor_expand,
    input  logic [1:0] divisor_expand_ex,
    output logic [2:0] q_table
);

    logic signed [13:0] p_est;
    logic        [7:0]  d_est;
    logic signed [13:0] d_x2;
    logic signed [13:0] d_x6;

    // p_est is in units of 2^-10, d_est in units of 2^-8; thresholds sit at
    // 0.5*d and 1.5*d, the middle of each overlap region, with ample margin
    // for the truncation error of both estimates.
    assign p_est = {dividend_index[6], dividend_index, dividend_expand, dividend_expand_ex};
    assign d_est = {divisor_index, divisor_expand, divisor_expand_ex};
    assign d_x2  = signed'({5'd0, d_est, 1'b0});
    assign d_x6  = d_x2 + signed'({4'd0, d_est, 2'b00});

    always_comb begin
        q_table = {1'b0, QD_MAG_0};
        if (p_est >= d_x6) begin
            q_table = {1'b0, QD_MAG_2};
        end else if (p_est >= d_x2) begin
            q_table = {1'b0, QD_MAG_1};
        end else if (p_est >= -d_x2) begin
            q_table = {1'b0, QD_MAG_0};
        end else if (p_est >= -d_x6) begin
            q_table = {1'b1, QD_MAG_1};
        end else begin
            q_table = {1'b1, QD_MAG_2};
        end
    end

endmodule

// File: rtl/radix4_srt_div.sv
// Sequential radix-4 SRT divider for RV32M DIV/DIVU/REM/REMU, one digit per cycle.
// Define DIV_EARLY_TERM_EN to finish |a| < |b| requests directly from NORM.
module radix4_srt_div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    function automatic logic [4:0] clz(input logic [XLEN-1:0] v);
        logic found;
        clz   = 5'd0;
        found = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                clz   = 5'(XLEN - 1 - i);
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        neg_if = neg ? (32'd0 - v) : v;
    endfunction

    state_e             state;
    logic [1:0]         op;
    logic               sign_q;
    logic               sign_r;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        divisor;
    logic [33:0]        x_low;
    logic signed [35:0] w;
    logic [33:0]        q_acc;
    logic [33:0]        qm_acc;
    logic [4:0]         cnt;
    logic [4:0]         lzd;

    logic               is_rem;
    logic               acc_signed;
    logic [31:0]        a_abs;
    logic [31:0]        b_abs;
    logic [31:0]        a_restored;
    logic [4:0]         lzd_now;
    logic [63:0]        x_norm;
    logic signed [37:0] p;
    logic signed [37:0] qd;
    logic [2:0]         q_table;
    logic               q_neg;
    logic [1:0]         q_mag;
    logic [33:0]        q_nxt;
    logic [33:0]        qm_nxt;
    logic signed [35:0] rem_raw;
    logic [33:0]        quo_raw;
    logic [31:0]        rem_fix;
    logic [31:0]        quo_fix;

    assign is_rem     = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    assign acc_signed = (in_op == DIV_OP_DIV) || (in_op == DIV_OP_REM);
    assign a_abs      = (acc_signed && in_a[31]) ? (32'd0 - in_a) : in_a;
    assign b_abs      = (acc_signed && in_b[31]) ? (32'd0 - in_b) : in_b;
    // sign_r is set exactly when the original dividend was negative
    assign a_restored = neg_if(a_mag, sign_r);

    assign lzd_now = clz(b_mag);
    assign x_norm  = {32'd0, a_mag} << lzd_now;

    assign p     = {w, x_low[33:32]};
    assign q_neg = q_table[QD_SIGN];
    assign q_mag = q_table[1:0];

    radix4_table u_table (
        .dividend_index     (p[34:28]),
        .divisor_index      (divisor[31:28]),
        .dividend_expand    (p[27:25]),
        .dividend_expand_ex (p[24:22]),
        .divisor_expand     (divisor[27:26]),
        .divisor_expand_ex  (divisor[25:24]),
        .q_table            (q_table)
    );

    always_comb begin
        qd = '0;
        case (q_mag)
            QD_MAG_1: qd = signed'({6'd0, divisor});
            QD_MAG_2: qd = signed'({5'd0, divisor, 1'b0});
            default:  qd = '0;
        endcase
    end

    // On-the-fly conversion keeps Q and QM = Q - 1 so a negative digit never borrows.
    always_comb begin
        q_nxt  = {q_acc[31:0], 2'b00};
        qm_nxt = {qm_acc[31:0], 2'b11};
        if (q_mag != QD_MAG_0) begin
            if (!q_neg) begin
                q_nxt  = {q_acc[31:0], q_mag};
                qm_nxt = {q_acc[31:0], q_mag - 2'd1};
            end else begin
                q_nxt  = {qm_acc[31:0], 2'd0 - q_mag};
                qm_nxt = {qm_acc[31:0], 2'd3 - q_mag};
            end
        end
    end

    assign rem_raw = w[35] ? (w + signed'({4'd0, divisor})) : w;
    assign quo_raw = w[35] ? qm_acc : q_acc;
    assign rem_fix = neg_if(32'(unsigned'(rem_raw) >> lzd), sign_r);
    assign quo_fix = 32'(sign_q ? (34'd0 - quo_raw) : quo_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            op         <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            a_mag      <= '0;
            b_mag      <= '0;
            divisor    <= '0;
            x_low      <= '0;
            w          <= '0;
            q_acc      <= '0;
            qm_acc     <= '0;
            cnt        <= '0;
            lzd        <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= in_op;
                        sign_q   <= acc_signed & (in_a[31] ^ in_b[31]);
                        sign_r   <= acc_signed & in_a[31];
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (b_mag == '0) begin
                        out_result <= is_rem ? a_restored : '1;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
`ifdef DIV_EARLY_TERM_EN
                    else if (a_mag < b_mag) begin
                        out_result <= is_rem ? a_restored : '0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
`endif
                    else begin
                        lzd     <= lzd_now;
                        divisor <= b_mag << lzd_now;
                        w       <= signed'({6'd0, x_norm[63:34]});
                        x_low   <= x_norm[33:0];
                        q_acc   <= '0;
                        qm_acc  <= '0;
                        cnt     <= '0;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    w      <= 36'(q_neg ? (p + qd) : (p - qd));
                    x_low  <= {x_low[31:0], 2'b00};
                    q_acc  <= q_nxt;
                    qm_acc <= qm_nxt;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'(ITERS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out_result <= is_rem ? rem_fix : quo_fix;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_srt_div.sv
// Bench for radix4_srt_div: directed RV32M cases, stall/flush behaviour and
// randomized operations against an integer-arithmetic reference model.
module tb_radix4_srt_div;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int     checks     = 0;
    int     errors     = 0;
    int     bound_viol = 0;
    longint w_abs;

    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE};

    radix4_srt_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    // RV32M semantics straight from integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qv, rv;
        if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0]) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qv = sa / sb;
        rv = sa % sb;
        return op[1] ? 32'(rv) : 32'(qv);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_TERM_EN
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
        if (b != 32'd0 && ma < mb) return 2;
`endif
        if (b == 32'd0) return 2;
        return 20;
    endfunction

    // Called at a negedge; returns at the negedge after the result was taken.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input logic [31:0] exp_v, input int exp_lat);
        int    cycles;
        string id;
        id = $sformatf("op%0d %h/%h", op, a, b);
        out_ready = (stall == 0);
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        cycles    = 0;
        while (!in_ready && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check({"accept ", id}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_op    = 2'($urandom);
        cycles   = 1;
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check({"latency ", id}, cycles, exp_lat);
        check({"result ", id}, out_result, exp_v);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({"hold_valid ", id}, out_valid, 1'b1);
            check({"hold_result ", id}, out_result, exp_v);
            check({"hold_in_ready ", id}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({"release ", id}, {out_valid, in_ready}, 2'b01);
    endtask

    always @(negedge clk) begin
        if (rst_n && (dut.state == ITER || dut.state == FIX)) begin
            w_abs = dut.w;
            if (w_abs < 0) w_abs = -w_abs;
            if (3 * w_abs > 2 * longint'(dut.divisor)) bound_viol++;
        end
    end

    initial begin
        int          seen;
        logic [1:0]  op;
        logic [31:0] a, b;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 0, 32'd14, 20);
        run_op(DIV_OP_REMU, 32'd100, 32'd7, 0, 32'd2, 20);
        run_op(DIV_OP_DIV, 32'hFFFFFF9C, 32'd7, 0, 32'hFFFFFFF2, 20);
        run_op(DIV_OP_REM, 32'hFFFFFF9C, 32'd7, 0, 32'hFFFFFFFE, 20);
        run_op(DIV_OP_DIV, 32'd100, 32'hFFFFFFF9, 0, 32'hFFFFFFF2, 20);
        run_op(DIV_OP_DIV, 32'h1234, 32'd0, 0, 32'hFFFFFFFF, 2);
        run_op(DIV_OP_REM, 32'h1234, 32'd0, 0, 32'h1234, 2);
        run_op(DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 20);
        run_op(DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, 20);
        run_op(DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1, 0, 32'hFFFFFFFF, 20);
        run_op(DIV_OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 32'd1, 20);

        // flush while idle must not accept the concurrent request
        in_op    = DIV_OP_DIVU;
        in_a     = 32'd50;
        in_b     = 32'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_idle_no_result", seen, 0);

        // flush during the 8th iteration cycle
        in_op    = DIV_OP_DIVU;
        in_a     = 32'd1000;
        in_b     = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("flush_busy_in_ready", in_ready, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_to_idle", {in_ready, out_valid}, 2'b10);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 0);
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, 0, 32'd3, 20);

        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    a = $urandom;
                    b = $urandom_range(0, 15);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: begin
                    a = corners[$urandom_range(0, 5)];
                    b = corners[$urandom_range(0, 5)];
                end
                default: begin a = $urandom_range(0, 255); b = $urandom; end
            endcase
            run_op(op, a, b, int'($urandom_range(0, 2)), ref_div(op, a, b), ref_lat(op, a, b));
        end

        check("w_bound_violations", bound_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
